// File: rtl/reg_dump_reader.sv
// Sequential RegFile dump engine: walks an inclusive, wrapping register range through
// one combinational read port and streams {addr,data} beats on a valid/ready handshake.
// It also snoops the RegFile write port and flags registers overwritten after capture.
module reg_dump_reader #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 1 << ADDR_W
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   firstReg,
    input  logic [ADDR_W-1:0]   lastReg,
    output logic [ADDR_W-1:0]   RegAddr,
    input  logic [DATA_W-1:0]   RegData,
    input  logic                regWrite,
    input  logic [ADDR_W-1:0]   writeAddr,
    output logic                outValid,
    input  logic                outReady,
    output logic [ADDR_W-1:0]   outAddr,
    output logic [DATA_W-1:0]   outData,
    output logic                busy,
    output logic                done,
    output logic [NUM_REGS-1:0] staleMask
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_OUT,
        S_DONE
    } state_e;

    state_e                state_q,     state_d;
    logic [ADDR_W-1:0]     ptr_q,       ptr_d;
    logic [ADDR_W-1:0]     last_q,      last_d;
    logic [ADDR_W-1:0]     out_addr_q,  out_addr_d;
    logic [DATA_W-1:0]     out_data_q,  out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic [NUM_REGS-1:0]   captured_q,  captured_d;
    logic [NUM_REGS-1:0]   stale_q,     stale_d;
    logic                  busy_w;
    logic                  write_is_stale;

    assign busy_w    = (state_q != S_IDLE);
    assign RegAddr   = ptr_q;
    assign outValid  = out_valid_q;
    assign outAddr   = out_addr_q;
    assign outData   = out_data_q;
    assign busy      = busy_w;
    assign done      = (state_q == S_DONE);
    assign staleMask = stale_q;

    // A write landing on the READ edge for ptr is stale too: the old value is what gets captured.
    assign write_is_stale = captured_q[writeAddr] ||
                            ((state_q == S_READ) && (writeAddr == ptr_q));

    always_comb begin
        // NOTE: every _d starts as its _q so each path through the case holds state without inferring a latch.
        state_d     = state_q;
        ptr_d       = ptr_q;
        last_d      = last_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        captured_d  = captured_q;
        stale_d     = stale_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    ptr_d      = firstReg;
                    last_d     = lastReg;
                    captured_d = '0;
                    stale_d    = '0;
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                out_data_d          = RegData;
                out_addr_d          = ptr_q;
                captured_d[ptr_q]   = 1'b1;
                out_valid_d         = 1'b1;
                state_d             = S_OUT;
            end
            S_OUT: begin
                if (outReady) begin
                    out_valid_d = 1'b0;
                    if (ptr_q == last_q) begin
                        state_d = S_DONE;
                    end else begin
                        ptr_d   = ptr_q + ADDR_W'(1);
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Idle writes never touch the mask, so a finished dump's result survives until the next start.
        if (busy_w && regWrite && write_is_stale) begin
            stale_d[writeAddr] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments here so every flop samples pre-edge values regardless of statement order.
        if (Reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            last_q      <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            captured_q  <= '0;
            stale_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            last_q      <= last_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            captured_q  <= captured_d;
            stale_q     <= stale_d;
        end
    end

endmodule
